// File: rtl/iob2axil_if.sv
// IOb request port plus AXI-Lite master channels of the iob2axil bridge.
// Member names are seen from the bridge: _i enters it, _o leaves it.
interface iob2axil_if #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
);
  logic                     iob_avalid_i;
  logic [AXIL_ADDR_W-1:0]   iob_addr_i;
  logic [AXIL_DATA_W-1:0]   iob_wdata_i;
  logic [AXIL_DATA_W/8-1:0] iob_wstrb_i;
  logic                     iob_ready_o;
  logic                     iob_rvalid_o;
  logic [AXIL_DATA_W-1:0]   iob_rdata_o;
  logic                     err_o;

  logic [AXIL_ADDR_W-1:0]   axil_awaddr_o;
  logic [2:0]               axil_awprot_o;
  logic                     axil_awvalid_o;
  logic                     axil_awready_i;
  logic [AXIL_DATA_W-1:0]   axil_wdata_o;
  logic [AXIL_DATA_W/8-1:0] axil_wstrb_o;
  logic                     axil_wvalid_o;
  logic                     axil_wready_i;
  logic [1:0]               axil_bresp_i;
  logic                     axil_bvalid_i;
  logic                     axil_bready_o;
  logic [AXIL_ADDR_W-1:0]   axil_araddr_o;
  logic [2:0]               axil_arprot_o;
  logic                     axil_arvalid_o;
  logic                     axil_arready_i;
  logic [AXIL_DATA_W-1:0]   axil_rdata_i;
  logic [1:0]               axil_rresp_i;
  logic                     axil_rvalid_i;
  logic                     axil_rready_o;

  modport slave (
    input  iob_avalid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    output iob_ready_o, iob_rvalid_o, iob_rdata_o, err_o,
    output axil_awaddr_o, axil_awprot_o, axil_awvalid_o,
    input  axil_awready_i,
    output axil_wdata_o, axil_wstrb_o, axil_wvalid_o,
    input  axil_wready_i,
    input  axil_bresp_i, axil_bvalid_i,
    output axil_bready_o,
    output axil_araddr_o, axil_arprot_o, axil_arvalid_o,
    input  axil_arready_i,
    input  axil_rdata_i, axil_rresp_i, axil_rvalid_i,
    output axil_rready_o
  );

  modport master (
    output iob_avalid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    input  iob_ready_o, iob_rvalid_o, iob_rdata_o, err_o,
    input  axil_awaddr_o, axil_awprot_o, axil_awvalid_o,
    output axil_awready_i,
    input  axil_wdata_o, axil_wstrb_o, axil_wvalid_o,
    output axil_wready_i,
    output axil_bresp_i, axil_bvalid_i,
    input  axil_bready_o,
    input  axil_araddr_o, axil_arprot_o, axil_arvalid_o,
    output axil_arready_i,
    output axil_rdata_i, axil_rresp_i, axil_rvalid_i,
    input  axil_rready_o
  );
endinterface

// File: rtl/iob2axil.sv
// IOb native slave to AXI-Lite master bridge.
// One transaction in flight; aw and w channels complete independently.
module iob2axil #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       cke_i,
  iob2axil_if.slave  bus
);
  localparam int SW = AXIL_DATA_W / 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [AXIL_ADDR_W-1:0] addr_q, addr_d;
  logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]          wstrb_q, wstrb_d;
  logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   rvalid_q, rvalid_d;
  logic                   err_q, err_d;

  logic st_idle, st_wreq, st_wrsp;
  logic st_rreq, st_rdat;
  logic awvalid, wvalid;
  logic aw_ok, w_ok;

  assign st_idle = (state_q == IDLE);
  assign st_wreq = (state_q == WR_REQ);
  assign st_wrsp = (state_q == WR_RESP);
  assign st_rreq = (state_q == RD_REQ);
  assign st_rdat = (state_q == RD_DATA);

  assign awvalid = st_wreq && !aw_done_q;
  assign wvalid  = st_wreq && !w_done_q;

  // A channel counts as done if it handshook earlier or does so now
  assign aw_ok = aw_done_q || (awvalid && bus.axil_awready_i);
  assign w_ok  = w_done_q || (wvalid && bus.axil_wready_i);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    unique case (1'b1)
      st_idle: begin
        if (bus.iob_avalid_i) begin
          addr_d  = bus.iob_addr_i;
          wdata_d = bus.iob_wdata_i;
          wstrb_d = bus.iob_wstrb_i;
          state_d = (|bus.iob_wstrb_i)
                  ? WR_REQ : RD_REQ;
        end
      end
      st_wreq: begin
        if (aw_ok && w_ok) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_ok;
          w_done_d  = w_ok;
        end
      end
      st_wrsp: begin
        if (bus.axil_bvalid_i) begin
          state_d = IDLE;
          err_d   = |bus.axil_bresp_i;
        end
      end
      st_rreq: begin
        if (bus.axil_arready_i) state_d = RD_DATA;
      end
      st_rdat: begin
        if (bus.axil_rvalid_i) begin
          state_d  = IDLE;
          rdata_d  = bus.axil_rdata_i;
          rvalid_d = 1'b1;
          err_d    = |bus.axil_rresp_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  assign bus.iob_ready_o    = st_idle;
  assign bus.iob_rvalid_o   = rvalid_q;
  assign bus.iob_rdata_o    = rdata_q;
  assign bus.err_o          = err_q;

  assign bus.axil_awaddr_o  = addr_q;
  assign bus.axil_awprot_o  = 3'b000;
  assign bus.axil_awvalid_o = awvalid;
  assign bus.axil_wdata_o   = wdata_q;
  assign bus.axil_wstrb_o   = wstrb_q;
  assign bus.axil_wvalid_o  = wvalid;
  assign bus.axil_bready_o  = st_wrsp;
  assign bus.axil_araddr_o  = addr_q;
  assign bus.axil_arprot_o  = 3'b000;
  assign bus.axil_arvalid_o = st_rreq;
  assign bus.axil_rready_o  = st_rdat;
endmodule

// File: doc/iob2axil.md
IOB2AXIL -- requirements
Module: iob2axil

Interface
REQ-001 SHALL have parameter AXIL_ADDR_W, default 32, AXI-Lite and IOb address width.
REQ-002 SHALL have parameter AXIL_DATA_W, default 32, AXI-Lite and IOb data width.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port arst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cke_i  in  1  clock enable; when low, all state and outputs hold.
REQ-006 SHALL have port iob_avalid_i  in  1  IOb request valid.
REQ-007 SHALL have port iob_addr_i  in  AXIL_ADDR_W  IOb byte address.
REQ-008 SHALL have port iob_wdata_i  in  AXIL_DATA_W  IOb write data.
REQ-009 SHALL have port iob_wstrb_i  in  AXIL_DATA_W/8  write strobes; zero means read.
REQ-010 SHALL have port iob_ready_o  out  1  request accepted when high with iob_avalid_i.
REQ-011 SHALL have port iob_rvalid_o  out  1  read data valid, one-cycle pulse.
REQ-012 SHALL have port iob_rdata_o  out  AXIL_DATA_W  read data.
REQ-013 SHALL have port err_o  out  1  one-cycle pulse on a non-OKAY bresp or rresp.
REQ-014 SHALL have AXI-Lite master write-address ports: axil_awaddr_o (out, AXIL_ADDR_W), axil_awprot_o (out, 3), axil_awvalid_o (out, 1), axil_awready_i (in, 1).
REQ-015 SHALL have AXI-Lite master write-data ports: axil_wdata_o (out, AXIL_DATA_W), axil_wstrb_o (out, AXIL_DATA_W/8), axil_wvalid_o (out, 1), axil_wready_i (in, 1).
REQ-016 SHALL have AXI-Lite master write-response ports: axil_bresp_i (in, 2), axil_bvalid_i (in, 1), axil_bready_o (out, 1).
REQ-017 SHALL have AXI-Lite master read-address ports: axil_araddr_o (out, AXIL_ADDR_W), axil_arprot_o (out, 3), axil_arvalid_o (out, 1), axil_arready_i (in, 1).
REQ-018 SHALL have AXI-Lite master read-data ports: axil_rdata_i (in, AXIL_DATA_W), axil_rresp_i (in, 2), axil_rvalid_i (in, 1), axil_rready_o (out, 1).

Function
REQ-019 SHALL implement a state machine with states IDLE, WR_REQ, WR_RESP, RD_REQ and RD_DATA.
REQ-020 SHALL drive iob_ready_o high only in IDLE; it SHALL be decoded combinationally from the state.
REQ-021 SHALL, on iob_avalid_i&&iob_ready_o in cycle T, register the address, wdata and wstrb and enter WR_REQ (wstrb!=0) or RD_REQ (wstrb==0) at T+1.
REQ-022 SHALL, in WR_REQ, assert axil_awvalid_o and axil_wvalid_o from the registered request; each valid SHALL drop independently after its own handshake, accepted in either order or together; the FSM SHALL enter WR_RESP in the cycle after both handshakes have completed.
REQ-023 SHALL, in WR_RESP, assert axil_bready_o; on axil_bvalid_i it SHALL return to IDLE and SHALL NOT pulse iob_rvalid_o.
REQ-024 SHALL, in RD_REQ, assert axil_arvalid_o until axil_arready_i, then enter RD_DATA.
REQ-025 SHALL, in RD_DATA, assert axil_rready_o; on axil_rvalid_i it SHALL register axil_rdata_i into iob_rdata_o, pulse iob_rvalid_o in the next cycle, and return to IDLE.
REQ-026 SHALL hold iob_rdata_o stable until the next read completes.
REQ-027 SHALL pulse err_o in the cycle after a response with resp!=2'b00; the transaction SHALL complete normally.
REQ-028 SHALL drive axil_awprot_o and axil_arprot_o as 3'b000.
REQ-029 SHALL keep all AXI valid signals stable while waiting for ready; no valid SHALL be asserted in IDLE.
REQ-030 SHALL give a minimum latency, with zero-wait slaves, of acceptance at T, iob_rvalid_o and iob_ready_o high at T+3 for reads, and iob_ready_o high at T+3 for writes.
REQ-031 SHALL ignore iob_avalid_i outside IDLE; at most one transaction SHALL be outstanding.

Reset
REQ-032 SHALL, while arst_n_i is low, force state to IDLE and clear all valid/ready outputs, iob_rvalid_o, err_o and iob_rdata_o to 0, with iob_ready_o high.
REQ-033 SHALL, on reset asserted mid-transaction, abandon the transaction and SHALL NOT emit iob_rvalid_o after deassertion.

Verification
REQ-034 SHALL cover: read addr 0x100 with zero-wait slave returning 0xDEADBEEF -> iob_rvalid_o at T+3, iob_rdata_o=0xDEADBEEF, err_o=0.
REQ-035 SHALL cover: write 0x12345678 with wstrb=0xF, awready 3 cycles before wready -> awvalid drops first, a single W beat, then bready, then iob_ready_o high.
REQ-036 SHALL cover: write with wready before awready, bvalid delayed 5 cycles -> iob_ready_o held low throughout, no iob_rvalid_o pulse.
REQ-037 SHALL cover: read with rresp=2'b10 -> iob_rvalid_o and a single err_o pulse in the same cycle.
REQ-038 SHALL cover: arst_n_i low during RD_DATA -> all outputs reset, no iob_rvalid_o afterward, next read succeeds.
REQ-039 SHALL cover: cke_i low for 4 cycles during WR_REQ -> awvalid/wvalid held, state unchanged, transaction completes after cke_i returns high.
